// File: rtl/approx_sqrt_ctrl.sv
// approx_sqrt_ctrl
// ----------------
// Sequencer for an external combinational approximation ALU. It computes the
// integer square root and remainder of a non-negative 8-bit signed operand by
// repeatedly subtracting 1, 3, 5, ... from it. The number of subtractions that
// stay non-negative is the root, and what is left over is the remainder.
// When VERIFY=1, a closing pass rebuilds root*root + rem on the ALU. It flags a
// mismatch against the latched operand.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   start_i        start request, sampled only while idle
//   x_i            signed operand (legal range 0..127)
//   busy_o         high while a computation is in progress
//   done_o         one-cycle completion pulse
//   root_o         floor(sqrt(x)), held until the next completion
//   rem_o          x - root*root, held until the next completion
//   err_o          negative operand or verify mismatch, held likewise
//   alu_mode_o     0 ADD_ONE, 1 SUB_ONE, 2 ADD_SUB, 3 MULTIPLY, 4 ALU_IDLE
//   alu_op_a_o     ALU operand A
//   alu_op_b_o     ALU operand B
//   alu_sigma_n_o  1 = A-B, 0 = A+B (ADD_SUB only)
//   alu_res_i      ALU result, valid in the cycle the operation is issued
module approx_sqrt_ctrl #(
  parameter bit VERIFY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  x_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  root_o,
  output logic [7:0]  rem_o,
  output logic        err_o,
  output logic [2:0]  alu_mode_o,
  output logic [7:0]  alu_op_a_o,
  output logic [7:0]  alu_op_b_o,
  output logic        alu_sigma_n_o,
  input  logic [15:0] alu_res_i
);

  localparam logic [2:0] MODE_ADD_ONE  = 3'd0;
  localparam logic [2:0] MODE_ADD_SUB  = 3'd2;
  localparam logic [2:0] MODE_MULTIPLY = 3'd3;
  localparam logic [2:0] MODE_IDLE     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUB,
    S_INC_R,
    S_INC_O1,
    S_INC_O2,
    S_VMUL,
    S_VADD,
    S_DONE
  } state_t;

  state_t     state_q;
  logic [7:0] rem_q;      // running remainder
  logic [7:0] odd_q;      // next odd number to subtract (peaks at 23)
  logic [3:0] r_q;        // running root (peaks at 11)
  logic [7:0] sq_q;       // root*root from the verify multiply
  logic [7:0] x_q;        // operand latched at the start edge
  logic       err_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] root_out_q;
  logic [7:0] rem_out_q;
  logic       err_out_q;

  // Legal operands keep every intermediate value within 0..127, so only the
  // low byte is ever captured. Bit 15 is the loop-exit sign test.
  logic unused_res_bits;
  assign unused_res_bits = ^alu_res_i[14:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      odd_q      <= '0;
      r_q        <= '0;
      sq_q       <= '0;
      x_q        <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      root_out_q <= '0;
      rem_out_q  <= '0;
      err_out_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            x_q <= x_i;
            if (x_i[7]) begin
              // A negative operand is rejected without touching the ALU.
              r_q        <= '0;
              rem_q      <= '0;
              err_q      <= 1'b1;
              root_out_q <= '0;
              rem_out_q  <= '0;
              err_out_q  <= 1'b1;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_DONE;
            end else begin
              rem_q   <= x_i;
              odd_q   <= 8'd1;
              r_q     <= '0;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_SUB;
            end
          end
        end
        S_SUB: begin
          if (alu_res_i[15]) begin
            // The subtraction went negative, so rem_q already holds the final remainder.
            if (VERIFY) begin
              state_q <= S_VMUL;
            end else begin
              root_out_q <= r_q;
              rem_out_q  <= rem_q;
              err_out_q  <= err_q;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_DONE;
            end
          end else begin
            rem_q   <= alu_res_i[7:0];
            state_q <= S_INC_R;
          end
        end
        S_INC_R: begin
          r_q     <= alu_res_i[3:0];
          state_q <= S_INC_O1;
        end
        S_INC_O1: begin
          odd_q   <= alu_res_i[7:0];
          state_q <= S_INC_O2;
        end
        S_INC_O2: begin
          odd_q   <= alu_res_i[7:0];
          state_q <= S_SUB;
        end
        S_VMUL: begin
          sq_q    <= alu_res_i[7:0];
          state_q <= S_VADD;
        end
        S_VADD: begin
          err_q      <= (alu_res_i[7:0] != x_q);
          root_out_q <= r_q;
          rem_out_q  <= rem_q;
          err_out_q  <= (alu_res_i[7:0] != x_q);
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The ALU request is a pure decode of the state and the internal registers.
  // It never depends on an input, so alu_res_i cannot form a combinational loop.
  always_comb begin
    alu_mode_o    = MODE_IDLE;
    alu_op_a_o    = '0;
    alu_op_b_o    = '0;
    alu_sigma_n_o = 1'b0;
    case (state_q)
      S_SUB: begin
        alu_mode_o    = MODE_ADD_SUB;
        alu_sigma_n_o = 1'b1;
        alu_op_a_o    = rem_q;
        alu_op_b_o    = odd_q;
      end
      S_INC_R: begin
        alu_mode_o = MODE_ADD_ONE;
        alu_op_a_o = {4'b0000, r_q};
      end
      S_INC_O1, S_INC_O2: begin
        alu_mode_o = MODE_ADD_ONE;
        alu_op_a_o = odd_q;
      end
      S_VMUL: begin
        alu_mode_o = MODE_MULTIPLY;
        alu_op_a_o = {4'b0000, r_q};
        alu_op_b_o = {4'b0000, r_q};
      end
      S_VADD: begin
        alu_mode_o = MODE_ADD_SUB;
        alu_op_a_o = sq_q;
        alu_op_b_o = rem_q;
      end
      default: begin
        alu_mode_o = MODE_IDLE;
      end
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign root_o = root_out_q;
  assign rem_o  = rem_out_q;
  assign err_o  = err_out_q;

endmodule

// File: tb/tb_approx_sqrt_ctrl.sv
// Testbench for approx_sqrt_ctrl. It drives two instances, one with VERIFY=1
// and one with VERIFY=0, and gives each a behavioural model of the ALU.
// Expected results are queued when each start is driven. They are popped and
// compared when done_o is seen.
module tb_approx_sqrt_ctrl;

  logic clk;
  logic rst;
  logic sel;          // 1 selects the VERIFY=1 instance
  logic start_drv;
  logic [7:0] x_drv;
  logic alu_fault;    // corrupts MULTIPLY results so that the verify pass trips

  logic start1, busy1, done1, err1, sig1;
  logic [3:0] root1;
  logic [7:0] rem1, a1, b1;
  logic [2:0] mode1;
  logic [15:0] res1;

  logic start0, busy0, done0, err0, sig0;
  logic [3:0] root0;
  logic [7:0] rem0, a0, b0;
  logic [2:0] mode0;
  logic [15:0] res0;

  logic done_m, busy_m, err_m;
  logic [3:0] root_m;
  logic [7:0] rem_m, a_m;
  logic [2:0] mode_m;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int root;
    int rem;
    int err;
    int k;
  } exp_t;
  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [2:0] m, input logic [7:0] a,
                                            input logic [7:0] b, input logic s, input logic f);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    case (m)
      3'd0: return sa + 16'sd1;
      3'd1: return sa - 16'sd1;
      3'd2: return s ? (sa - sb) : (sa + sb);
      3'd3: return (sa * sb) + (f ? 16'sd1 : 16'sd0);
      default: return 16'd0;
    endcase
  endfunction

  assign res1 = alu_model(mode1, a1, b1, sig1, alu_fault);
  assign res0 = alu_model(mode0, a0, b0, sig0, alu_fault);

  assign start1 = sel & start_drv;
  assign start0 = ~sel & start_drv;

  assign done_m = sel ? done1 : done0;
  assign busy_m = sel ? busy1 : busy0;
  assign err_m  = sel ? err1  : err0;
  assign root_m = sel ? root1 : root0;
  assign rem_m  = sel ? rem1  : rem0;
  assign mode_m = sel ? mode1 : mode0;
  assign a_m    = sel ? a1    : a0;

  approx_sqrt_ctrl #(.VERIFY(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .x_i(x_drv),
    .busy_o(busy1), .done_o(done1), .root_o(root1), .rem_o(rem1), .err_o(err1),
    .alu_mode_o(mode1), .alu_op_a_o(a1), .alu_op_b_o(b1), .alu_sigma_n_o(sig1),
    .alu_res_i(res1)
  );

  approx_sqrt_ctrl #(.VERIFY(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .x_i(x_drv),
    .busy_o(busy0), .done_o(done0), .root_o(root0), .rem_o(rem0), .err_o(err0),
    .alu_mode_o(mode0), .alu_op_a_o(a0), .alu_op_b_o(b0), .alu_sigma_n_o(sig0),
    .alu_res_i(res0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input bit verify, input bit fault);
    exp_t e;
    int xv;
    int r;
    if (x[7]) begin
      e.root = 0; e.rem = 0; e.err = 1; e.k = 0;
    end else begin
      xv = int'(x);
      r = 0;
      while ((r + 1) * (r + 1) <= xv) r++;
      e.root = r;
      e.rem  = xv - r * r;
      e.err  = (verify && fault) ? 1 : 0;
      e.k    = 4 * r + (verify ? 3 : 1);
    end
    return e;
  endfunction

  // One transaction: start is sampled by the posedge that follows the first
  // negedge here (edge 0). k counts edges until done_o is observed.
  task automatic run_op(input logic [7:0] x, input bit verify, input bit hold,
                        input bit fault, input int ignore_at);
    exp_t e;
    int k;
    int busy_bad;
    bit seen;
    bit saw_mul;
    bit saw_active;
    sb_q.push_back(model(x, verify, fault));
    @(negedge clk);
    x_drv = x;
    alu_fault = fault;
    start_drv = 1'b1;
    @(negedge clk);
    if (!hold) start_drv = 1'b0;
    k = 0; busy_bad = 0; seen = 1'b0; saw_mul = 1'b0; saw_active = 1'b0;
    while (!seen && k < 200) begin
      if (mode_m == 3'd3) saw_mul = 1'b1;
      if (mode_m != 3'd4) saw_active = 1'b1;
      if (done_m) begin
        seen = 1'b1;
      end else begin
        if (!busy_m) busy_bad++;
        if (k == ignore_at - 1) start_drv = 1'b1;
        else if (!hold) start_drv = 1'b0;
        k++;
        @(negedge clk);
      end
    end
    e = sb_q.pop_front();
    check("latency_k", k, e.k);
    check("root", {28'd0, root_m}, e.root);
    check("rem", {24'd0, rem_m}, e.rem);
    check("err", {31'd0, err_m}, e.err);
    check("busy_during_op_gaps", busy_bad, 0);
    check("busy_at_done", {31'd0, busy_m}, 0);
    if (!verify) check("no_multiply_issued", {31'd0, saw_mul}, 0);
    if (x[7]) check("no_alu_op_on_error", {31'd0, saw_active}, 0);
    $display("[TB] op verify=%0d x=%0d -> root=%0d rem=%0d err=%0d k=%0d",
             verify, x, root_m, rem_m, err_m, k);
  endtask

  initial begin
    int bad;
    rst = 1'b0;
    sel = 1'b1;
    start_drv = 1'b0;
    x_drv = 8'd0;
    alu_fault = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state for both instances
    check("rst_busy", {30'd0, busy1, busy0}, 0);
    check("rst_done", {30'd0, done1, done0}, 0);
    check("rst_err", {30'd0, err1, err0}, 0);
    check("rst_root", {24'd0, root1, root0}, 0);
    check("rst_rem", {16'd0, rem1, rem0}, 0);
    check("rst_mode1", {29'd0, mode1}, 4);
    check("rst_mode0", {29'd0, mode0}, 4);
    check("rst_ops", {16'd0, a1, b1}, 0);
    check("rst_sigma", {30'd0, sig1, sig0}, 0);
    @(negedge clk);
    rst = 1'b1;

    // VERIFY=1 instance
    run_op(8'd10, 1'b1, 1'b0, 1'b0, -1);
    run_op(8'd0, 1'b1, 1'b0, 1'b0, -1);
    run_op(8'd127, 1'b1, 1'b1, 1'b0, -1);   // start held high through DONE
    run_op(8'd64, 1'b1, 1'b0, 1'b0, -1);    // accepted right after DONE
    run_op(8'hFB, 1'b1, 1'b0, 1'b0, -1);    // negative operand
    run_op(8'd30, 1'b1, 1'b0, 1'b0, -1);
    run_op(8'd10, 1'b1, 1'b0, 1'b1, -1);    // faulty multiply must raise err

    // Reset in the middle of x=100
    @(negedge clk);
    x_drv = 8'd100;
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy1}, 0);
    check("abort_done", {31'd0, done1}, 0);
    check("abort_root", {28'd0, root1}, 0);
    check("abort_rem_err", {23'd0, rem1, err1}, 0);
    check("abort_mode", {29'd0, mode1}, 4);
    check("abort_op_a", {24'd0, a_m}, 0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done1 || busy1) bad++;
    end
    check("abort_no_done", bad, 0);
    run_op(8'd49, 1'b1, 1'b0, 1'b0, -1);

    // VERIFY=0 instance, with a stray start pulse sampled at edge 5
    sel = 1'b0;
    run_op(8'd50, 1'b0, 1'b0, 1'b0, 5);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done0 || busy0) bad++;
    end
    check("v0_stray_start_ignored", bad, 0);
    run_op(8'd127, 1'b0, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
